// File: rtl/branch_pred_ctrl.sv
// rtl/branch_pred_ctrl.sv - branch prediction sequencer: counter table, in-order prediction queue, mispredict recovery
//
// Purpose:
//   Predicts conditional jumps from a table of 2-bit saturating counters,
//   queues outstanding predictions in order, presents the oldest (head) to
//   the checker, trains the table on resolution, and flushes plus stalls
//   new predictions for RECOVER_CYC cycles after a mispredict.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pred_req/pred_pc/pred_type    prediction request from fetch
//   pred_ready                    request can be accepted this cycle
//   pred_taken                    combinational prediction for pred_pc
//   head_valid/head_pred/head_type  oldest outstanding prediction
//   chk_valid/chk_incorrect/chk_correct  checker result for the head
//   flush/redirect_taken          registered mispredict pulse and direction
//   count                         number of queued predictions
//   underflow                     sticky: result arrived with empty queue

module branch_pred_ctrl #(
  parameter int PC_W        = 16,
  parameter int IDX_W       = 4,
  parameter int DEPTH       = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pred_req,
  input  logic [PC_W-1:0]              pred_pc,
  input  logic [1:0]                   pred_type,
  output logic                         pred_ready,
  output logic                         pred_taken,
  output logic                         head_valid,
  output logic                         head_pred,
  output logic [1:0]                   head_type,
  input  logic                         chk_valid,
  input  logic                         chk_incorrect,
  input  logic                         chk_correct,
  output logic                         flush,
  output logic                         redirect_taken,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RC_W  = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam int TBL_N = 1 << IDX_W;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic [1:0]       tbl_q [TBL_N];
  logic [1:0]       tbl_d [TBL_N];
  logic [IDX_W-1:0] q_idx_q [DEPTH];
  logic [IDX_W-1:0] q_idx_d [DEPTH];
  logic [1:0]       q_type_q [DEPTH];
  logic [1:0]       q_type_d [DEPTH];
  logic             q_pred_q [DEPTH];
  logic             q_pred_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_q, flush_d;
  logic             redir_q, redir_d;
  logic             uflow_q, uflow_d;

  logic             in_run;
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] train_idx;
  logic [1:0]       train_ctr;
  logic             resolve;
  logic             mispredict;
  logic             push;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^pred_pc[PC_W-1:IDX_W];

  assign in_run     = (state_q == ST_RUN);
  assign pred_idx   = pred_pc[IDX_W-1:0];
  assign pred_ready = in_run && (count_q < CNT_W'(DEPTH));
  // Reads the registered table, so a same-cycle training update is not visible.
  assign pred_taken = tbl_q[pred_idx][1];
  assign head_valid = in_run && (count_q != '0);
  assign head_pred  = head_valid & q_pred_q[head_q];
  assign head_type  = head_valid ? q_type_q[head_q] : 2'b00;

  assign resolve    = chk_valid && head_valid;
  assign mispredict = resolve && chk_incorrect;
  // A push in the same cycle as a mispredict is wrong-path and is dropped.
  assign push       = pred_req && pred_ready && (pred_type != 2'b00) && !mispredict;

  assign train_idx  = q_idx_q[head_q];
  assign train_ctr  = tbl_q[train_idx];

  assign flush          = flush_q;
  assign redirect_taken = redir_q;
  assign count          = count_q;
  assign underflow      = uflow_q;

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    for (int i = 0; i < TBL_N; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      q_idx_d[i]  = q_idx_q[i];
      q_type_d[i] = q_type_q[i];
      q_pred_d[i] = q_pred_q[i];
    end
    flush_d = mispredict;
    redir_d = mispredict ? chk_correct : redir_q;
    // Results during RECOVER are ignored entirely, including for underflow.
    uflow_d = uflow_q | (in_run && chk_valid && (count_q == '0));

    if (resolve) begin
      if (chk_correct) begin
        if (train_ctr != 2'b11) tbl_d[train_idx] = train_ctr + 2'b01;
      end else begin
        if (train_ctr != 2'b00) tbl_d[train_idx] = train_ctr - 2'b01;
      end
      head_d = head_q + 1'b1;
    end

    if (push) begin
      q_idx_d[tail_q]  = pred_idx;
      q_type_d[tail_q] = pred_type;
      q_pred_d[tail_q] = pred_taken;
      tail_d           = tail_q + 1'b1;
    end

    if (push && !resolve) begin
      count_d = count_q + 1'b1;
    end else if (resolve && !push) begin
      count_d = count_q - 1'b1;
    end

    if (mispredict) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      state_d   = ST_RECOVER;
      rec_cnt_d = RC_W'(RECOVER_CYC - 1);
    end else if (state_q == ST_RECOVER) begin
      if (rec_cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        rec_cnt_d = rec_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      rec_cnt_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      flush_q   <= 1'b0;
      redir_q   <= 1'b0;
      uflow_q   <= 1'b0;
      for (int i = 0; i < TBL_N; i++) begin
        tbl_q[i] <= 2'b01;
      end
      for (int i = 0; i < DEPTH; i++) begin
        q_idx_q[i]  <= '0;
        q_type_q[i] <= 2'b00;
        q_pred_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
      uflow_q   <= uflow_d;
      for (int i = 0; i < TBL_N; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
        q_idx_q[i]  <= q_idx_d[i];
        q_type_q[i] <= q_type_d[i];
        q_pred_q[i] <= q_pred_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb/tb_branch_pred_ctrl.sv - directed self-checking bench for branch_pred_ctrl

module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [15:0] pred_pc;
  logic [1:0]  pred_type;
  logic        pred_ready;
  logic        pred_taken;
  logic        head_valid;
  logic        head_pred;
  logic [1:0]  head_type;
  logic        chk_valid;
  logic        chk_incorrect;
  logic        chk_correct;
  logic        flush;
  logic        redirect_taken;
  logic [2:0]  count;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_type      (pred_type),
    .pred_ready     (pred_ready),
    .pred_taken     (pred_taken),
    .head_valid     (head_valid),
    .head_pred      (head_pred),
    .head_type      (head_type),
    .chk_valid      (chk_valid),
    .chk_incorrect  (chk_incorrect),
    .chk_correct    (chk_correct),
    .flush          (flush),
    .redirect_taken (redirect_taken),
    .count          (count),
    .underflow      (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pt(input string tag, input logic [15:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    check(tag, pred_taken, exp);
  endtask

  // One push of pc followed by a non-mispredict resolution with the given direction.
  task automatic train(input logic [15:0] pc, input logic taken);
    pred_pc   = pc;
    pred_type = 2'b01;
    pred_req  = 1'b1;
    tick();
    pred_req      = 1'b0;
    chk_valid     = 1'b1;
    chk_incorrect = 1'b0;
    chk_correct   = taken;
    tick();
    chk_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pred_req = 1'b0; pred_pc = '0; pred_type = 2'b00;
    chk_valid = 1'b0; chk_incorrect = 1'b0; chk_correct = 1'b0;
    tick();
    tick();
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_taken, 0);
    check("rst_underflow", underflow, 0);
    check("rst_head_valid", head_valid, 0);
    check("rst_count", count, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", pred_ready, 1);

    // Illegal type is ignored.
    pred_req = 1'b1; pred_pc = 16'h0005; pred_type = 2'b00;
    tick();
    check("type00_count", count, 0);

    // First prediction from a weakly-not-taken counter.
    pred_pc = 16'h0013; pred_type = 2'b01;
    #1;
    check("p1_taken", pred_taken, 0);
    tick();
    pred_req = 1'b0;
    check("p1_count", count, 1);
    check("p1_head_valid", head_valid, 1);
    check("p1_head_pred", head_pred, 0);
    check("p1_head_type", head_type, 2'b01);

    // Mispredict, actual taken: flush, two-cycle recovery, counter[3] -> 10.
    chk_valid = 1'b1; chk_incorrect = 1'b1; chk_correct = 1'b1;
    tick();
    chk_valid = 1'b0; chk_incorrect = 1'b0; chk_correct = 1'b0;
    check("mp_flush", flush, 1);
    check("mp_redirect", redirect_taken, 1);
    check("mp_count", count, 0);
    check("mp_ready_c1", pred_ready, 0);
    check("mp_head_valid", head_valid, 0);
    tick();
    check("mp_flush_c2", flush, 0);
    check("mp_ready_c2", pred_ready, 0);
    tick();
    check("mp_ready_run", pred_ready, 1);
    pt("mp_trained_pc3", 16'h0003, 1);

    // Fill the queue with pcs 0..3.
    pred_type = 2'b10;
    pred_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pred_pc = 16'(i);
      tick();
    end
    check("full_count", count, 4);
    check("full_ready", pred_ready, 0);
    pred_pc = 16'h0007; pred_type = 2'b01;
    tick();
    pred_req = 1'b0;
    check("full_drop_count", count, 4);
    check("full_head_pred", head_pred, 0);
    check("full_head_type", head_type, 2'b10);

    // Retire pc0, then push pc8 while retiring pc1.
    chk_valid = 1'b1; chk_incorrect = 1'b0; chk_correct = 1'b0;
    tick();
    check("ret1_count", count, 3);
    check("ret1_ready", pred_ready, 1);
    pred_req = 1'b1; pred_pc = 16'h0008; pred_type = 2'b11;
    tick();
    pred_req = 1'b0;
    check("pushpop_count", count, 3);
    check("pushpop_head_type", head_type, 2'b10);
    // Retire pc2; head becomes pc3 predicted taken.
    tick();
    check("pc3_head_pred", head_pred, 1);
    chk_correct = 1'b1;
    tick();
    check("pc8_head_type", head_type, 2'b11);
    check("pc8_head_pred", head_pred, 0);
    chk_correct = 1'b0;
    tick();
    chk_valid = 1'b0;
    check("drain_count", count, 0);
    check("drain_head_valid", head_valid, 0);
    check("drain_underflow", underflow, 0);

    // Saturation of counter[5].
    for (int i = 0; i < 4; i++) train(16'h0005, 1'b1);
    train(16'h0005, 1'b0);
    pt("sat_11_to_10", 16'h0005, 1);
    train(16'h0005, 1'b0);
    train(16'h0005, 1'b0);
    pt("sat_down_00", 16'h0005, 0);
    train(16'h0005, 1'b0);
    pt("sat_floor_00", 16'h0005, 0);
    train(16'h0005, 1'b1);
    pt("floor_then_01", 16'h0005, 0);
    train(16'h0005, 1'b1);
    pt("floor_then_10", 16'h0005, 1);

    // Mispredict pop with two queued and a same-cycle push.
    pred_type = 2'b01; pred_req = 1'b1;
    pred_pc = 16'h000A;
    tick();
    pred_pc = 16'h000B;
    tick();
    check("two_count", count, 2);
    pred_pc = 16'h000C;
    chk_valid = 1'b1; chk_incorrect = 1'b1; chk_correct = 1'b0;
    tick();
    pred_req = 1'b0;
    check("mpush_flush", flush, 1);
    check("mpush_redirect", redirect_taken, 0);
    check("mpush_count", count, 0);
    check("mpush_head_valid", head_valid, 0);
    // Results during recovery are ignored.
    chk_incorrect = 1'b0;
    tick();
    tick();
    chk_valid = 1'b0;
    check("rec_no_underflow", underflow, 0);
    check("rec_done_ready", pred_ready, 1);
    check("mpush_absent", count, 0);
    chk_valid = 1'b1;
    tick();
    chk_valid = 1'b0;
    check("underflow_set", underflow, 1);
    tick();
    tick();
    check("underflow_sticky", underflow, 1);

    // Reset in the second recovery cycle.
    pred_pc = 16'h0001; pred_type = 2'b01; pred_req = 1'b1;
    tick();
    pred_req = 1'b0;
    chk_valid = 1'b1; chk_incorrect = 1'b1; chk_correct = 1'b1;
    tick();
    chk_valid = 1'b0; chk_incorrect = 1'b0; chk_correct = 1'b0;
    check("r7_flush", flush, 1);
    tick();
    check("r7_in_recover", pred_ready, 0);
    rst = 1'b1;
    tick();
    check("r7_ready", pred_ready, 1);
    check("r7_flush_clear", flush, 0);
    check("r7_underflow_clear", underflow, 0);
    check("r7_count", count, 0);
    rst = 1'b0;
    tick();
    check("r7_no_residual_flush", flush, 0);
    check("r7_redirect", redirect_taken, 0);
    pt("r7_ctr5_reset", 16'h0005, 0);
    pt("r7_ctr3_reset", 16'h0003, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
